// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the frog game datapath: the life-manager state enum,
// counter widths and game-area geometry shared with the collision and render
// blocks.
// Contents:
//   state_t      - life-manager FSM states
//   TILE_SIZE    - playfield tile edge in pixels
//   LIVES_W      - width of the lives counter
//   LEVEL_W      - width of the level counter
//   timer_width  - width needed for a frame timer holding either frame count
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_GRACE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int TILE_SIZE = 16;
  localparam int LIVES_W   = 2;
  localparam int LEVEL_W   = 4;

  // Never returns 0 so that frame counts of 0 still produce a legal vector.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Loadable down-counter advanced by the per-frame tick. A load in the same
// cycle as a tick wins, so the tick is not counted. The count holds at zero.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   tick       in   one-cycle pulse per video frame
//   load       in   load request
//   load_value in   value loaded when load is high
//   zero       out  count is zero
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/frog_life_manager.sv
// -----------------------------------------------------------------------------
// frog_life_manager
// Game-state stage after the frog/car collision detector. Owns lives, level,
// death/respawn timing, post-respawn invulnerability and game-over. All
// outputs are registered and change one cycle after their cause.
// Ports:
//   i_Clk           in   system clock
//   i_Rst_L         in   synchronous reset, active-low
//   i_Frame_Tick    in   one-cycle pulse per video frame
//   i_Start         in   start/restart request (used in IDLE/GAME_OVER only)
//   i_Has_Collided  in   registered collision flag
//   i_Frog_Y        in   frog top-left Y
//   o_Lives         out  remaining lives
//   o_Level         out  current level
//   o_Respawn       out  pulse: frog reloads its start position
//   o_Level_Up      out  pulse: crossing completed
//   o_Freeze        out  frog movement inhibited
//   o_Invulnerable  out  high during the post-respawn grace period
//   o_Game_Over     out  high once all lives are spent
// -----------------------------------------------------------------------------
module frog_life_manager
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_FRAMES = 30,
  parameter int GOAL_Y       = 0,
  parameter int MAX_LEVEL    = 15
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Frame_Tick,
  input  logic               i_Start,
  input  logic               i_Has_Collided,
  input  logic [9:0]         i_Frog_Y,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic               o_Respawn,
  output logic               o_Level_Up,
  output logic               o_Freeze,
  output logic               o_Invulnerable,
  output logic               o_Game_Over
);

  localparam int TIMER_W = timer_width(DEATH_FRAMES, GRACE_FRAMES);

  state_t state, next_state;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               timer_zero;

  // Events decided by the next-state logic and consumed by the output logic.
  logic ev_start, ev_hit, ev_goal, ev_respawn;

  logic               goal_reached;
  logic [LIVES_W-1:0] lives_next;
  logic [LEVEL_W-1:0] level_next;
  logic               respawn_next, level_up_next;
  logic               freeze_next, invulnerable_next, game_over_next;

  assign goal_reached = (i_Frog_Y <= 10'(GOAL_Y));

  frame_timer #(
    .WIDTH(TIMER_W)
  ) u_frame_timer (
    .clk        (i_Clk),
    .rst_n      (i_Rst_L),
    .tick       (i_Frame_Tick),
    .load       (timer_load),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  // State and registered outputs. The outputs are computed from next_state so
  // they line up with the state register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state          <= ST_IDLE;
      o_Lives        <= LIVES_W'(START_LIVES);
      o_Level        <= '0;
      o_Respawn      <= 1'b0;
      o_Level_Up     <= 1'b0;
      o_Freeze       <= 1'b1;
      o_Invulnerable <= 1'b0;
      o_Game_Over    <= 1'b0;
    end else begin
      state          <= next_state;
      o_Lives        <= lives_next;
      o_Level        <= level_next;
      o_Respawn      <= respawn_next;
      o_Level_Up     <= level_up_next;
      o_Freeze       <= freeze_next;
      o_Invulnerable <= invulnerable_next;
      o_Game_Over    <= game_over_next;
    end
  end

  // Next state, timer loads and game events. The timer is loaded on the edge
  // that enters DYING/GRACE, so a tick in that cycle is swallowed by the load.
  always_comb begin
    next_state       = state;
    timer_load       = 1'b0;
    timer_load_value = '0;
    ev_start         = 1'b0;
    ev_hit           = 1'b0;
    ev_goal          = 1'b0;
    ev_respawn       = 1'b0;

    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_Start) begin
          next_state       = ST_GRACE;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(GRACE_FRAMES);
          ev_start         = 1'b1;
        end
      end

      ST_PLAY: begin
        // A collision outranks reaching the goal in the same cycle.
        if (i_Has_Collided) begin
          next_state       = ST_DYING;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(DEATH_FRAMES);
          ev_hit           = 1'b1;
        end else if (goal_reached) begin
          next_state       = ST_GRACE;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(GRACE_FRAMES);
          ev_goal          = 1'b1;
        end
      end

      ST_DYING: begin
        // o_Lives has already been decremented on entry to DYING.
        if (timer_zero) begin
          if (o_Lives == '0) begin
            next_state = ST_GAME_OVER;
          end else begin
            next_state       = ST_GRACE;
            timer_load       = 1'b1;
            timer_load_value = TIMER_W'(GRACE_FRAMES);
            ev_respawn       = 1'b1;
          end
        end
      end

      ST_GRACE: begin
        if (timer_zero) begin
          next_state = ST_PLAY;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    lives_next        = o_Lives;
    level_next        = o_Level;
    respawn_next      = ev_start | ev_goal | ev_respawn;
    level_up_next     = ev_goal;
    freeze_next       = (next_state == ST_IDLE) || (next_state == ST_DYING) ||
                        (next_state == ST_GAME_OVER);
    invulnerable_next = (next_state == ST_GRACE);
    game_over_next    = (next_state == ST_GAME_OVER);

    if (ev_start) begin
      lives_next = LIVES_W'(START_LIVES);
      level_next = '0;
    end

    if (ev_hit && (o_Lives != '0)) begin
      lives_next = o_Lives - LIVES_W'(1);
    end

    if (ev_goal && (o_Level < LEVEL_W'(MAX_LEVEL))) begin
      level_next = o_Level + LEVEL_W'(1);
    end
  end

endmodule

// File: tb/tb_frog_life_manager.sv
// -----------------------------------------------------------------------------
// tb_frog_life_manager
// Directed bench for frog_life_manager. A behavioural model tracks lives,
// level and the remaining frames of each timed phase; a compare process checks
// every output against it on each falling edge, and the directed sequence adds
// hand-computed literal checks at the key points.
// -----------------------------------------------------------------------------
module tb_frog_life_manager;

  localparam int START_LIVES  = 3;
  localparam int DEATH_FRAMES = 60;
  localparam int GRACE_FRAMES = 30;
  localparam int GOAL_Y       = 0;
  localparam int MAX_LEVEL    = 15;
  localparam logic [9:0] FAR_Y = 10'd200;

  logic       i_Clk;
  logic       i_Rst_L;
  logic       i_Frame_Tick;
  logic       i_Start;
  logic       i_Has_Collided;
  logic [9:0] i_Frog_Y;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Respawn;
  logic       o_Level_Up;
  logic       o_Freeze;
  logic       o_Invulnerable;
  logic       o_Game_Over;

  int checks = 0;
  int errors = 0;

  frog_life_manager #(
    .START_LIVES  (START_LIVES),
    .DEATH_FRAMES (DEATH_FRAMES),
    .GRACE_FRAMES (GRACE_FRAMES),
    .GOAL_Y       (GOAL_Y),
    .MAX_LEVEL    (MAX_LEVEL)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Start        (i_Start),
    .i_Has_Collided (i_Has_Collided),
    .i_Frog_Y       (i_Frog_Y),
    .o_Lives        (o_Lives),
    .o_Level        (o_Level),
    .o_Respawn      (o_Respawn),
    .o_Level_Up     (o_Level_Up),
    .o_Freeze       (o_Freeze),
    .o_Invulnerable (o_Invulnerable),
    .o_Game_Over    (o_Game_Over)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Model: game phase plus frames left in the current timed phase.
  localparam int M_WAIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DEAD  = 2;
  localparam int M_SAFE  = 3;
  localparam int M_OVER  = 4;

  int m_phase   = M_WAIT;
  int m_left    = 0;
  int m_lives   = START_LIVES;
  int m_level   = 0;
  int m_respawn = 0;
  int m_lvlup   = 0;
  bit m_valid   = 1'b0;

  always @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      m_phase   = M_WAIT;
      m_left    = 0;
      m_lives   = START_LIVES;
      m_level   = 0;
      m_respawn = 0;
      m_lvlup   = 0;
      m_valid   = 1'b1;
    end else begin
      m_respawn = 0;
      m_lvlup   = 0;
      if (m_phase == M_WAIT || m_phase == M_OVER) begin
        if (i_Start) begin
          m_lives = START_LIVES;
          m_level = 0;
          m_phase = M_SAFE;
          m_left  = GRACE_FRAMES;
          m_respawn = 1;
        end
      end else if (m_phase == M_RUN) begin
        if (i_Has_Collided) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_phase = M_DEAD;
          m_left  = DEATH_FRAMES;
        end else if (int'(i_Frog_Y) <= GOAL_Y) begin
          m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
          m_phase = M_SAFE;
          m_left  = GRACE_FRAMES;
          m_respawn = 1;
          m_lvlup   = 1;
        end
      end else begin
        if (m_left == 0) begin
          if (m_phase == M_SAFE) begin
            m_phase = M_RUN;
          end else if (m_lives == 0) begin
            m_phase = M_OVER;
          end else begin
            m_phase = M_SAFE;
            m_left  = GRACE_FRAMES;
            m_respawn = 1;
          end
        end else if (i_Frame_Tick) begin
          m_left = m_left - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge i_Clk) begin
    if (m_valid) begin
      checkOutput("model_lives", int'(o_Lives), m_lives);
      checkOutput("model_level", int'(o_Level), m_level);
      checkOutput("model_respawn", int'(o_Respawn), m_respawn);
      checkOutput("model_level_up", int'(o_Level_Up), m_lvlup);
      checkOutput("model_freeze", int'(o_Freeze),
                  (m_phase == M_WAIT || m_phase == M_DEAD || m_phase == M_OVER) ? 1 : 0);
      checkOutput("model_invulnerable", int'(o_Invulnerable), (m_phase == M_SAFE) ? 1 : 0);
      checkOutput("model_game_over", int'(o_Game_Over), (m_phase == M_OVER) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs, then wait until the outputs of that edge settle.
  task automatic applyStimulus(input logic rst_l, input logic start, input logic coll,
                               input logic [9:0] y, input logic tick);
    i_Rst_L        = rst_l;
    i_Start        = start;
    i_Has_Collided = coll;
    i_Frog_Y       = y;
    i_Frame_Tick   = tick;
    @(negedge i_Clk);
  endtask

  // n frame ticks, each followed by one quiet cycle.
  task automatic runTicks(input int n, input logic start, input logic coll, input logic [9:0] y);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, start, coll, y, 1'b1);
      applyStimulus(1'b1, start, coll, y, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Rst_L        = 1'b0;
    i_Start        = 1'b0;
    i_Has_Collided = 1'b0;
    i_Frog_Y       = FAR_Y;
    i_Frame_Tick   = 1'b0;
    @(negedge i_Clk);
    applyStimulus(1'b0, 1'b0, 1'b0, FAR_Y, 1'b0);
    $display("[TB] reset state");
    checkOutput("reset_lives", int'(o_Lives), 3);
    checkOutput("reset_level", int'(o_Level), 0);
    checkOutput("reset_freeze", int'(o_Freeze), 1);
    checkOutput("reset_respawn", int'(o_Respawn), 0);
    checkOutput("reset_game_over", int'(o_Game_Over), 0);

    // Start with a tick on the same cycle: the load must swallow that tick.
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, FAR_Y, 1'b1);
    $display("[TB] start");
    checkOutput("start_respawn", int'(o_Respawn), 1);
    checkOutput("start_lives", int'(o_Lives), 3);
    checkOutput("start_invulnerable", int'(o_Invulnerable), 1);
    checkOutput("start_freeze", int'(o_Freeze), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
    checkOutput("start_respawn_single", int'(o_Respawn), 0);
    runTicks(GRACE_FRAMES - 1, 1'b0, 1'b0, FAR_Y);
    checkOutput("grace_29_still_invulnerable", int'(o_Invulnerable), 1);
    runTicks(1, 1'b0, 1'b0, FAR_Y);
    checkOutput("grace_30_play", int'(o_Invulnerable), 0);

    // First hit, death timing and a collision held through GRACE.
    $display("[TB] first hit");
    applyStimulus(1'b1, 1'b0, 1'b1, FAR_Y, 1'b0);
    checkOutput("hit1_lives", int'(o_Lives), 2);
    checkOutput("hit1_freeze", int'(o_Freeze), 1);
    runTicks(DEATH_FRAMES - 1, 1'b0, 1'b0, FAR_Y);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b1);
    checkOutput("dying_last_tick_no_respawn", int'(o_Respawn), 0);
    checkOutput("dying_last_tick_freeze", int'(o_Freeze), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
    checkOutput("dying_exit_respawn", int'(o_Respawn), 1);
    checkOutput("dying_exit_invulnerable", int'(o_Invulnerable), 1);
    runTicks(GRACE_FRAMES, 1'b0, 1'b1, FAR_Y);
    checkOutput("grace_collision_ignored", int'(o_Lives), 2);
    checkOutput("grace_to_play", int'(o_Invulnerable), 0);

    // Crossings and level saturation.
    $display("[TB] crossings");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    checkOutput("goal_level_up", int'(o_Level_Up), 1);
    checkOutput("goal_respawn", int'(o_Respawn), 1);
    checkOutput("goal_level", int'(o_Level), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
    checkOutput("goal_pulse_single", int'(o_Level_Up), 0);
    runTicks(GRACE_FRAMES, 1'b0, 1'b0, FAR_Y);
    for (int g = 0; g < 15; g++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
      runTicks(GRACE_FRAMES, 1'b0, 1'b0, FAR_Y);
    end
    checkOutput("level_saturated", int'(o_Level), 15);

    // Collision and goal together: collision wins.
    $display("[TB] collision with goal");
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 1'b0);
    checkOutput("tie_lives", int'(o_Lives), 1);
    checkOutput("tie_no_level_up", int'(o_Level_Up), 0);
    checkOutput("tie_no_respawn", int'(o_Respawn), 0);
    checkOutput("tie_freeze", int'(o_Freeze), 1);
    checkOutput("tie_level", int'(o_Level), 15);
    runTicks(DEATH_FRAMES, 1'b0, 1'b0, FAR_Y);
    checkOutput("hit2_respawn", int'(o_Respawn), 1);
    runTicks(GRACE_FRAMES, 1'b0, 1'b0, FAR_Y);

    // Last life lost, then restart with i_Start held high.
    $display("[TB] game over and restart");
    applyStimulus(1'b1, 1'b0, 1'b1, FAR_Y, 1'b0);
    checkOutput("hit3_lives", int'(o_Lives), 0);
    runTicks(DEATH_FRAMES, 1'b0, 1'b0, FAR_Y);
    checkOutput("over_game_over", int'(o_Game_Over), 1);
    checkOutput("over_lives", int'(o_Lives), 0);
    checkOutput("over_no_respawn", int'(o_Respawn), 0);
    checkOutput("over_freeze", int'(o_Freeze), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, FAR_Y, 1'b0);
    checkOutput("restart_lives", int'(o_Lives), 3);
    checkOutput("restart_level", int'(o_Level), 0);
    checkOutput("restart_game_over", int'(o_Game_Over), 0);
    checkOutput("restart_respawn", int'(o_Respawn), 1);
    runTicks(GRACE_FRAMES, 1'b1, 1'b0, FAR_Y);
    applyStimulus(1'b1, 1'b1, 1'b0, FAR_Y, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, FAR_Y, 1'b0);
    checkOutput("start_held_no_respawn", int'(o_Respawn), 0);
    checkOutput("start_held_playing", int'(o_Freeze), 0);

    // Reset in the middle of DYING, coinciding with a frame tick.
    $display("[TB] reset mid-dying");
    applyStimulus(1'b1, 1'b0, 1'b1, FAR_Y, 1'b0);
    checkOutput("hit4_lives", int'(o_Lives), 2);
    runTicks(10, 1'b0, 1'b0, FAR_Y);
    applyStimulus(1'b0, 1'b0, 1'b0, FAR_Y, 1'b1);
    checkOutput("midreset_lives", int'(o_Lives), 3);
    checkOutput("midreset_freeze", int'(o_Freeze), 1);
    checkOutput("midreset_respawn", int'(o_Respawn), 0);
    checkOutput("midreset_invulnerable", int'(o_Invulnerable), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, FAR_Y, 1'b0);
    checkOutput("idle_stays_frozen", int'(o_Freeze), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
